// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit and its datapath:
// opcodes, FSM state encoding, instruction layout and CW bit positions.
package control_unit_pkg;

    localparam int CW_W = 13;

    // Control word field positions, shared with the datapath.
    localparam int CW_DA_LSB = 11;
    localparam int CW_AA_LSB = 9;
    localparam int CW_BA_LSB = 7;
    localparam int CW_MB     = 6;
    localparam int CW_FS_LSB = 2;
    localparam int CW_MD     = 1;
    localparam int CW_RW     = 0;

    // Opcodes; 8..15 are reserved and decode as NOP.
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ALUR = 4'd1;
    localparam logic [3:0] OP_ALUI = 4'd2;
    localparam logic [3:0] OP_LD   = 4'd3;
    localparam logic [3:0] OP_ST   = 4'd4;
    localparam logic [3:0] OP_JMP  = 4'd5;
    localparam logic [3:0] OP_BRZ  = 4'd6;
    localparam logic [3:0] OP_HALT = 4'd7;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_EXEC   = 2'd1,
        ST_LDWAIT = 2'd2,
        ST_HALT   = 2'd3
    } state_e;

    // Instruction layout; the low nibble is either BA (upper two bits)
    // or the 4-bit immediate, depending on the opcode.
    typedef struct packed {
        logic [3:0] op;
        logic [3:0] fs;
        logic [1:0] da;
        logic [1:0] aa;
        logic [3:0] low;
    } instr_t;

    // Assemble a control word from its fields.
    function automatic logic [CW_W-1:0] make_cw(
        input logic [1:0] da,
        input logic [1:0] aa,
        input logic [1:0] ba,
        input logic       mb,
        input logic [3:0] fs,
        input logic       md,
        input logic       rw
    );
        logic [CW_W-1:0] w;
        w                    = '0;
        w[CW_DA_LSB +: 2]    = da;
        w[CW_AA_LSB +: 2]    = aa;
        w[CW_BA_LSB +: 2]    = ba;
        w[CW_MB]             = mb;
        w[CW_FS_LSB +: 4]    = fs;
        w[CW_MD]             = md;
        w[CW_RW]             = rw;
        return w;
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational decode of (state, IR, A-bus) into the datapath control
// word, constant, memory write enable and branch-taken flag.
module cu_decode
    import control_unit_pkg::*;
(
    input  state_e            state_i,
    input  logic [15:0]       ir_i,
    input  logic [3:0]        a_val_i,
    output logic [CW_W-1:0]   cw_o,
    output logic [3:0]        cn_o,
    output logic              mw_o,
    output logic              branch_o
);

    instr_t     ir;
    logic [1:0] ba;
    logic       a_zero;

    assign ir     = instr_t'(ir_i);
    assign ba     = ir.low[3:2];
    assign a_zero = (a_val_i == 4'd0);

    // Outputs are all-zero unless the state/opcode pair enables a field.
    always_comb begin
        cw_o     = '0;
        cn_o     = 4'd0;
        mw_o     = 1'b0;
        branch_o = 1'b0;
        case (state_i)
            ST_EXEC: begin
                case (ir.op)
                    OP_ALUR: begin
                        cw_o = make_cw(ir.da, ir.aa, ba, 1'b0,
                                       ir.fs, 1'b0, 1'b1);
                    end
                    OP_ALUI: begin
                        cw_o = make_cw(ir.da, ir.aa, 2'b00, 1'b1,
                                       ir.fs, 1'b0, 1'b1);
                        cn_o = ir.low;
                    end
                    OP_LD: begin
                        // Address goes out now; write-back waits for
                        // the synchronous memory in LDWAIT.
                        cw_o = make_cw(2'b00, ir.aa, 2'b00, 1'b0,
                                       4'd0, 1'b1, 1'b0);
                    end
                    OP_ST: begin
                        cw_o = make_cw(2'b00, ir.aa, ba, 1'b0,
                                       4'd0, 1'b0, 1'b0);
                        mw_o = 1'b1;
                    end
                    OP_JMP: begin
                        branch_o = 1'b1;
                    end
                    OP_BRZ: begin
                        cw_o     = make_cw(2'b00, ir.aa, 2'b00, 1'b0,
                                           4'd0, 1'b0, 1'b0);
                        branch_o = a_zero;
                    end
                    default: begin
                    end
                endcase
            end
            ST_LDWAIT: begin
                cw_o = make_cw(ir.da, ir.aa, 2'b00, 1'b0,
                               4'd0, 1'b1, 1'b1);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: FETCH / EXEC / LDWAIT / HALT sequencer that
// owns PC, IR and state and drives the datapath through cu_decode.
module control_unit
    import control_unit_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic [15:0]       INSTR,
    input  logic [3:0]        A_VAL,
    output logic [3:0]        PC,
    output logic [CW_W-1:0]   CW,
    output logic [3:0]        CN,
    output logic              MW,
    output logic              HALTED
);

    state_e      state_q, state_d;
    logic [3:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        branch;
    instr_t      ir;

    assign ir = instr_t'(ir_q);

    cu_decode u_decode (
        .state_i  (state_q),
        .ir_i     (ir_q),
        .a_val_i  (A_VAL),
        .cw_o     (CW),
        .cn_o     (CN),
        .mw_o     (MW),
        .branch_o (branch)
    );

    // State, PC and IR registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_FETCH;
            pc_q    <= 4'd0;
            ir_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state logic; a taken branch replaces the PC already
    // incremented during FETCH.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_FETCH: begin
                ir_d    = INSTR;
                pc_d    = pc_q + 4'd1;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (branch) begin
                    pc_d = ir.low;
                end
                if (ir.op == OP_LD) begin
                    state_d = ST_LDWAIT;
                end else if (ir.op == OP_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_LDWAIT: begin
                state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    assign PC     = pc_q;
    assign HALTED = (state_q == ST_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Scenario bench for control_unit: ROM model, hand-derived per-cycle
// expectations queued in a scoreboard and compared at the falling edge.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] instr;
    logic [3:0]  a_val = 4'd0;
    logic [3:0]  pc;
    logic [12:0] cw;
    logic [3:0]  cn;
    logic        mw;
    logic        halted;

    logic [15:0] rom [16];

    typedef struct packed {
        logic [3:0]  pc;
        logic [12:0] cw;
        logic [3:0]  cn;
        logic        mw;
        logic        h;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    control_unit dut (
        .CLK    (clk),
        .RST    (rst),
        .INSTR  (instr),
        .A_VAL  (a_val),
        .PC     (pc),
        .CW     (cw),
        .CN     (cn),
        .MW     (mw),
        .HALTED (halted)
    );

    assign instr = rom[pc];

    always #5 clk = ~clk;

    function automatic logic [12:0] cwf(int da, int aa, int ba, int mb,
                                        int fs, int md, int rw);
        return {da[1:0], aa[1:0], ba[1:0], mb[0], fs[3:0], md[0], rw[0]};
    endfunction

    function automatic logic [15:0] ins(int op, int fs, int da, int aa,
                                        int lo);
        return {op[3:0], fs[3:0], da[1:0], aa[1:0], lo[3:0]};
    endfunction

    task automatic push(int p, logic [12:0] w, int c, int m, int h);
        exp_t e;
        e.pc = p[3:0];
        e.cw = w;
        e.cn = c[3:0];
        e.mw = m[0];
        e.h  = h[0];
        sb.push_back(e);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    endtask

    // Called at a falling edge; returns at the falling edge of cycle 0.
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        clear_rom();
        rom[0] = ins(2, 2, 1, 0, 5);
        do_reset();
        push(0, 13'd0, 0, 0, 0);
        push(1, cwf(1, 0, 0, 1, 2, 0, 1), 5, 0, 0);
        for (int k = 0; k < 2; k++) begin
            if (k > 0) @(negedge clk);
            e = sb.pop_front();
            n_tests++;
            if ({pc, cw, cn, mw, halted} !== e) begin
                n_fail++;
                $display("FAIL reset c%0d: got pc=%h cw=%h cn=%h mw=%b h=%b exp pc=%h cw=%h cn=%h mw=%b h=%b",
                         k, pc, cw, cn, mw, halted, e.pc, e.cw, e.cn, e.mw, e.h);
            end
        end
        do_reset();
        push(0, 13'd0, 0, 0, 0);
        e = sb.pop_front();
        n_tests++;
        if ({pc, cw, cn, mw, halted} !== e) begin
            n_fail++;
            $display("FAIL reset_from_exec: got pc=%h cw=%h cn=%h mw=%b h=%b exp pc=%h cw=%h",
                     pc, cw, cn, mw, halted, e.pc, e.cw);
        end
    endtask

    task automatic test_alu();
        exp_t e;
        clear_rom();
        rom[0] = ins(2, 2, 1, 0, 5);
        rom[1] = ins(1, 5, 2, 1, 4'b1100);
        rom[2] = ins(9, 7, 3, 3, 15);
        do_reset();
        push(0, 13'd0, 0, 0, 0);
        push(1, cwf(1, 0, 0, 1, 2, 0, 1), 5, 0, 0);
        push(1, 13'd0, 0, 0, 0);
        push(2, cwf(2, 1, 3, 0, 5, 0, 1), 0, 0, 0);
        push(2, 13'd0, 0, 0, 0);
        push(3, 13'd0, 0, 0, 0);
        push(3, 13'd0, 0, 0, 0);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge clk);
            e = sb.pop_front();
            n_tests++;
            if ({pc, cw, cn, mw, halted} !== e) begin
                n_fail++;
                $display("FAIL alu c%0d: got pc=%h cw=%h cn=%h mw=%b h=%b exp pc=%h cw=%h cn=%h mw=%b h=%b",
                         k, pc, cw, cn, mw, halted, e.pc, e.cw, e.cn, e.mw, e.h);
            end
        end
    endtask

    task automatic test_brz();
        exp_t e;
        clear_rom();
        rom[3] = ins(6, 0, 0, 2, 9);
        for (int run = 0; run < 2; run++) begin
            a_val = (run == 0) ? 4'd0 : 4'd3;
            do_reset();
            for (int c = 0; c < 4; c++) begin
                push(c, 13'd0, 0, 0, 0);
                push(c + 1, (c == 3) ? cwf(0, 2, 0, 0, 0, 0, 0) : 13'd0,
                     0, 0, 0);
            end
            push((run == 0) ? 9 : 4, 13'd0, 0, 0, 0);
            for (int k = 0; k < 9; k++) begin
                if (k > 0) @(negedge clk);
                e = sb.pop_front();
                n_tests++;
                if ({pc, cw, cn, mw, halted} !== e) begin
                    n_fail++;
                    $display("FAIL brz a=%0d c%0d: got pc=%h cw=%h cn=%h mw=%b exp pc=%h cw=%h",
                             a_val, k, pc, cw, cn, mw, e.pc, e.cw);
                end
            end
        end
        a_val = 4'd0;
    endtask

    task automatic test_jmp_loop();
        exp_t e;
        clear_rom();
        rom[0] = ins(5, 3, 2, 1, 7);
        rom[7] = ins(5, 0, 0, 0, 7);
        do_reset();
        push(0, 13'd0, 0, 0, 0);
        push(1, 13'd0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            push(7, 13'd0, 0, 0, 0);
            push(8, 13'd0, 0, 0, 0);
        end
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            e = sb.pop_front();
            n_tests++;
            if ({pc, cw, cn, mw, halted} !== e) begin
                n_fail++;
                $display("FAIL jmp c%0d: got pc=%h cw=%h exp pc=%h cw=%h",
                         k, pc, cw, e.pc, e.cw);
            end
        end
    endtask

    task automatic test_ld();
        exp_t e;
        clear_rom();
        rom[0] = ins(3, 0, 3, 0, 0);
        rom[1] = ins(3, 6, 1, 2, 12);
        do_reset();
        push(0, 13'd0, 0, 0, 0);
        push(1, cwf(0, 0, 0, 0, 0, 1, 0), 0, 0, 0);
        push(1, cwf(3, 0, 0, 0, 0, 1, 1), 0, 0, 0);
        push(1, 13'd0, 0, 0, 0);
        push(2, cwf(0, 2, 0, 0, 0, 1, 0), 0, 0, 0);
        push(2, cwf(1, 2, 0, 0, 0, 1, 1), 0, 0, 0);
        push(2, 13'd0, 0, 0, 0);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge clk);
            e = sb.pop_front();
            n_tests++;
            if ({pc, cw, cn, mw, halted} !== e) begin
                n_fail++;
                $display("FAIL ld c%0d: got pc=%h cw=%h mw=%b exp pc=%h cw=%h mw=%b",
                         k, pc, cw, mw, e.pc, e.cw, e.mw);
            end
        end
    endtask

    task automatic test_st_wrap();
        exp_t e;
        clear_rom();
        rom[0]  = ins(5, 0, 0, 0, 15);
        rom[15] = ins(4, 9, 3, 1, 8);
        do_reset();
        push(0, 13'd0, 0, 0, 0);
        push(1, 13'd0, 0, 0, 0);
        push(15, 13'd0, 0, 0, 0);
        push(0, cwf(0, 1, 2, 0, 0, 0, 0), 0, 1, 0);
        push(0, 13'd0, 0, 0, 0);
        push(1, 13'd0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            e = sb.pop_front();
            n_tests++;
            if ({pc, cw, cn, mw, halted} !== e) begin
                n_fail++;
                $display("FAIL st_wrap c%0d: got pc=%h cw=%h mw=%b exp pc=%h cw=%h mw=%b",
                         k, pc, cw, mw, e.pc, e.cw, e.mw);
            end
        end
    endtask

    task automatic test_halt();
        exp_t e;
        clear_rom();
        rom[0] = ins(1, 4, 1, 1, 4);
        rom[1] = ins(7, 15, 3, 3, 15);
        do_reset();
        push(0, 13'd0, 0, 0, 0);
        push(1, cwf(1, 1, 1, 0, 4, 0, 1), 0, 0, 0);
        push(1, 13'd0, 0, 0, 0);
        push(2, 13'd0, 0, 0, 0);
        for (int i = 0; i < 20; i++) push(2, 13'd0, 0, 0, 1);
        for (int k = 0; k < 24; k++) begin
            if (k > 0) @(negedge clk);
            e = sb.pop_front();
            n_tests++;
            if ({pc, cw, cn, mw, halted} !== e) begin
                n_fail++;
                $display("FAIL halt c%0d: got pc=%h cw=%h mw=%b h=%b exp pc=%h cw=%h h=%b",
                         k, pc, cw, mw, halted, e.pc, e.cw, e.h);
            end
        end
        do_reset();
        push(0, 13'd0, 0, 0, 0);
        push(1, cwf(1, 1, 1, 0, 4, 0, 1), 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            if (k > 0) @(negedge clk);
            e = sb.pop_front();
            n_tests++;
            if ({pc, cw, cn, mw, halted} !== e) begin
                n_fail++;
                $display("FAIL halt_reset c%0d: got pc=%h cw=%h h=%b exp pc=%h cw=%h h=%b",
                         k, pc, cw, halted, e.pc, e.cw, e.h);
            end
        end
    endtask

    task automatic test_ld_reset();
        exp_t e;
        clear_rom();
        rom[0] = ins(3, 0, 3, 1, 0);
        do_reset();
        push(0, 13'd0, 0, 0, 0);
        push(1, cwf(0, 1, 0, 0, 0, 1, 0), 0, 0, 0);
        push(1, cwf(3, 1, 0, 0, 0, 1, 1), 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            e = sb.pop_front();
            n_tests++;
            if ({pc, cw, cn, mw, halted} !== e) begin
                n_fail++;
                $display("FAIL ld_reset c%0d: got pc=%h cw=%h exp pc=%h cw=%h",
                         k, pc, cw, e.pc, e.cw);
            end
        end
        do_reset();
        push(0, 13'd0, 0, 0, 0);
        push(1, cwf(0, 1, 0, 0, 0, 1, 0), 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            if (k > 0) @(negedge clk);
            e = sb.pop_front();
            n_tests++;
            if ({pc, cw, cn, mw, halted} !== e) begin
                n_fail++;
                $display("FAIL ld_reset_after c%0d: got pc=%h cw=%h mw=%b exp pc=%h cw=%h",
                         k, pc, cw, mw, e.pc, e.cw);
            end
        end
    endtask

    initial begin
        clear_rom();
        @(negedge clk);
        test_reset();
        test_alu();
        test_brz();
        test_jmp_loop();
        test_ld();
        test_st_wrap();
        test_halt();
        test_ld_reset();
        n_tests++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, need 0",
                     sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameters: none; all widths fixed (4-bit data, 4-bit PC, 16-bit instruction, 13-bit CW).
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 INSTR  input  16  instruction word from program ROM at address PC; valid combinationally.
REQ-005 A_VAL  input  4  datapath A-bus value (ADDR_OUT), used for branch test.
REQ-006 PC  output  4  program counter, registered; drives ROM address.
REQ-007 CW  output  13  control word to datapath: [12:11] DA, [10:9] AA, [8:7] BA, [6] MB, [5:2] FS, [1] MD, [0] RW.
REQ-008 CN  output  4  constant to datapath.
REQ-009 MW  output  1  data-memory write enable.
REQ-010 HALTED  output  1  high while in HALT state.

Function
REQ-011 Instruction fields: op=[15:12], FS=[11:8], DA=[7:6], AA=[5:4], BA=[3:2], IMM=[3:0].
REQ-012 States: FETCH, EXEC, LDWAIT, HALT.
REQ-013 FETCH: IR<=INSTR, PC<=PC+1 (mod 16, 15 wraps to 0), next EXEC; CW=0, CN=0, MW=0.
REQ-014 EXEC next state: LDWAIT if op=LD, HALT if op=HALT, else FETCH.
REQ-015 Opcodes in EXEC: 0 NOP (CW=0); 1 ALUR (DA,AA,BA,FS, MB=0, MD=0, RW=1); 2 ALUI (DA,AA,FS, MB=1, CN=IMM, MD=0, RW=1); 3 LD (AA, MD=1, RW=0); 4 ST (AA,BA, MB=0, MW=1); 5 JMP (PC<=IMM); 6 BRZ (AA; PC<=IMM if A_VAL==0, else PC unchanged); 7 HALT; 8-15 behave as NOP.
REQ-016 LDWAIT: CW carries DA, AA, MD=1, RW=1 (synchronous-read data memory delivers DATA_IN this cycle); next FETCH.
REQ-017 HALT: CW=0, MW=0, PC frozen, HALTED=1; remains until RST.
REQ-018 CW, CN, MW are combinational decodes of (state, IR); all fields not listed for an opcode are 0.
REQ-019 Latency: LD 3 cycles; all other opcodes 2 cycles; HALT reached 2 cycles after its FETCH.
REQ-020 RW and MW never both 1 in one cycle; RW=1 only in EXEC (ALUR/ALUI) or LDWAIT.
REQ-021 JMP/BRZ target overrides the FETCH increment; a branch to its own address loops indefinitely.

Reset
REQ-022 RST high at a clock edge: state=FETCH, PC=0, IR=0, HALTED=0; CW=0, CN=0, MW=0 from the following cycle.
REQ-023 RST overrides any state, including mid-LD (LDWAIT) and HALT; no write (RW/MW) is issued in the cycle after reset.

Structure
REQ-024 Shared package holds opcode constants, state encoding, and CW field bit positions; the datapath uses the same field positions.
REQ-025 One sub-module, cu_decode: combinational (state, IR, A_VAL) -> {CW, CN, MW, branch_taken}; registers (PC, IR, state) remain in control_unit.

Verification
REQ-026 RST then ROM[0]=ALUI DA=1 FS=add IMM=5 -> cycle 1 CW: DA=01, MB=1, RW=1, CN=5; PC=1 after FETCH.
REQ-027 ROM[3]=BRZ AA=2 IMM=9: A_VAL=0 -> PC=9; A_VAL=3 -> PC=4.
REQ-028 LD DA=3 AA=0 -> EXEC RW=0 MD=1; LDWAIT RW=1 MD=1 DA=11; next instruction fetched 3 cycles after LD fetch.
REQ-029 ST at PC=15 -> MW=1 only in EXEC, RW=0; PC wraps to 0.
REQ-030 HALT -> HALTED=1, PC, CW constant over 20 cycles; RST during HALT -> PC=0, FETCH resumes.
REQ-031 RST asserted in LDWAIT -> no RW pulse, next cycle PC=0, state FETCH.
